// File: rtl/sha_nonce_feeder_if.sv
// ---------------------------------------------------------------------------
// sha_nonce_feeder_if
//   Groups the run-control, message-issue and result-pairing signals of
//   sha_nonce_feeder into one bundle.
//
//   master : the controlling side (host logic / testbench). Drives start,
//            stop, hdr_tail, the nonce range and res_valid (sha_block en_next).
//   slave  : the feeder itself. Drives M/en toward sha_block, the paired
//            res_nonce/res_nonce_valid, and the busy/done/err status.
//
//   `MSG_S is the sha_block message width (512 bits by default).
// ---------------------------------------------------------------------------
`ifndef MSG_S
`define MSG_S 512
`endif

interface sha_nonce_feeder_if;
  logic               start;
  logic               stop;
  logic [95:0]        hdr_tail;
  logic [31:0]        nonce_start;
  logic [31:0]        nonce_end;
  logic [`MSG_S-1:0]  M;
  logic               en;
  logic               res_valid;
  logic [31:0]        res_nonce;
  logic               res_nonce_valid;
  logic               busy;
  logic               done;
  logic               err;

  modport master (
    output start, stop, hdr_tail, nonce_start, nonce_end, res_valid,
    input  M, en, res_nonce, res_nonce_valid, busy, done, err
  );

  modport slave (
    input  start, stop, hdr_tail, nonce_start, nonce_end, res_valid,
    output M, en, res_nonce, res_nonce_valid, busy, done, err
  );
endinterface

// File: rtl/sha_nonce_feeder.sv
// ---------------------------------------------------------------------------
// sha_nonce_feeder
//   Upstream stage of sha_block. Latches a 96-bit header tail and a nonce
//   range, then issues one padded 512-bit message per nonce with a one-cycle
//   en strobe. Every issued nonce is held in a FIFO and popped when sha_block
//   returns a result (res_valid), so each hash is paired with its nonce.
//
// Parameters
//   FIFO_DEPTH : in-flight nonce capacity (power of 2, >= sha_block latency+1)
//   ISSUE_GAP  : minimum cycles between en pulses (1..255)
//
// Ports
//   clk, reset : clock, synchronous active-high reset
//   bus        : sha_nonce_feeder_if.slave
//                start/stop/hdr_tail/nonce_start/nonce_end/res_valid in,
//                M/en/res_nonce/res_nonce_valid/busy/done/err out
//   issued_cnt : (FEEDER_STATS_EN only) en pulses since last accepted start
//   stall_cnt  : (FEEDER_STATS_EN only) RUN cycles blocked only by a full FIFO
//
// Optional feature macro: FEEDER_STATS_EN
// ---------------------------------------------------------------------------
`ifndef MSG_S
`define MSG_S 512
`endif

module sha_nonce_feeder #(
  parameter int FIFO_DEPTH = 16,
  parameter int ISSUE_GAP  = 1
) (
  input  logic               clk,
  input  logic               reset,
  sha_nonce_feeder_if.slave  bus
`ifdef FEEDER_STATS_EN
  ,
  output logic [31:0]        issued_cnt,
  output logic [31:0]        stall_cnt
`endif
);

  localparam int              AW         = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int              CW         = AW + 1;
  localparam logic [CW-1:0]   FULL_C     = CW'(FIFO_DEPTH);
  localparam logic [7:0]      GAP_RELOAD = 8'(ISSUE_GAP - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [95:0]        hdr_q, hdr_d;
  logic [31:0]        nonce_q, nonce_d;
  logic [31:0]        end_q, end_d;
  logic [7:0]         gap_q, gap_d;
  logic [`MSG_S-1:0]  m_q, m_d;
  logic               en_q, en_d;
  logic               err_q, err_d;

  logic [31:0]        fifo_mem [FIFO_DEPTH];
  logic [AW-1:0]      wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]      cnt_q, cnt_d;

  logic               fifo_full, fifo_empty;
  logic               accept, issue, push, pop;

  // Padded SHA-256 block for an 80-byte header: tail, nonce, the 0x80
  // terminator, zero fill and the 640-bit message length.
  function automatic logic [`MSG_S-1:0] build_msg(input logic [95:0] hdr,
                                                  input logic [31:0] nonce);
    build_msg = {hdr, nonce, 32'h80000000, 320'd0, 32'h00000280};
  endfunction

  assign fifo_full  = (cnt_q == FULL_C);
  assign fifo_empty = (cnt_q == '0);
  assign accept     = (state_q == S_IDLE) && bus.start;
  // stop outranks an issue slot; full is judged before any same-cycle pop.
  assign issue      = (state_q == S_RUN) && !bus.stop && (gap_q == 8'd0) && !fifo_full;
  assign push       = issue;
  assign pop        = bus.res_valid && !fifo_empty;

  // ---- stage 0: next-state / issue decision ----
  always_comb begin
    state_d = state_q;
    hdr_d   = hdr_q;
    nonce_d = nonce_q;
    end_d   = end_q;
    gap_d   = gap_q;
    m_d     = m_q;
    en_d    = 1'b0;
    err_d   = err_q;

    if (gap_q != 8'd0) gap_d = gap_q - 8'd1;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          hdr_d   = bus.hdr_tail;
          nonce_d = bus.nonce_start;
          end_d   = bus.nonce_end;
          gap_d   = 8'd0;
          err_d   = 1'b0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (bus.stop) begin
          state_d = S_DRAIN;
        end else if (issue) begin
          en_d  = 1'b1;
          m_d   = build_msg(hdr_q, nonce_q);
          gap_d = GAP_RELOAD;
          if (nonce_q == end_q) state_d = S_DRAIN;
          else                  nonce_d = nonce_q + 32'd1;  // wraps mod 2^32
        end
      end
      S_DRAIN: begin
        if (fifo_empty) state_d = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // A result with nothing in flight is a pairing fault; it overrides the
    // clear from a same-cycle start so it is never lost.
    if (bus.res_valid && fifo_empty) err_d = 1'b1;
  end

  always_comb begin
    cnt_d = cnt_q;
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // ---- stage 1: registered control, message and FIFO ----
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      gap_q    <= 8'd0;
      m_q      <= '0;
      en_q     <= 1'b0;
      err_q    <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      state_q <= state_d;
      gap_q   <= gap_d;
      m_q     <= m_d;
      en_q    <= en_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
    end
  end

  always_ff @(posedge clk) begin
    hdr_q   <= hdr_d;
    nonce_q <= nonce_d;
    end_q   <= end_d;
    if (push) fifo_mem[wr_ptr_q] <= nonce_q;
  end

  assign bus.M               = m_q;
  assign bus.en              = en_q;
  assign bus.res_nonce       = fifo_mem[rd_ptr_q];
  assign bus.res_nonce_valid = pop;
  assign bus.busy            = (state_q == S_RUN) || (state_q == S_DRAIN);
  assign bus.done            = (state_q == S_DONE);
  assign bus.err             = err_q;

`ifdef FEEDER_STATS_EN
  logic        stall_full;
  logic [31:0] issued_q, stall_q;

  assign stall_full = (state_q == S_RUN) && !bus.stop && (gap_q == 8'd0) && fifo_full;

  always_ff @(posedge clk) begin
    if (reset || accept) begin
      issued_q <= 32'd0;
      stall_q  <= 32'd0;
    end else begin
      if (issue && (issued_q != 32'hFFFFFFFF))     issued_q <= issued_q + 32'd1;
      if (stall_full && (stall_q != 32'hFFFFFFFF)) stall_q  <= stall_q + 32'd1;
    end
  end

  assign issued_cnt = issued_q;
  assign stall_cnt  = stall_q;
`endif

endmodule

// File: tb/tb_sha_nonce_feeder.sv
module tb_sha_nonce_feeder;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  sha_nonce_feeder_if ia();
  sha_nonce_feeder_if ib();
  sha_nonce_feeder_if ic();

`ifdef FEEDER_STATS_EN
  logic [31:0] a_issued, a_stall, b_issued, b_stall, c_issued, c_stall;
`endif

  sha_nonce_feeder #(.FIFO_DEPTH(16), .ISSUE_GAP(1)) dut_a (
    .clk(clk), .reset(reset), .bus(ia)
`ifdef FEEDER_STATS_EN
    , .issued_cnt(a_issued), .stall_cnt(a_stall)
`endif
  );
  sha_nonce_feeder #(.FIFO_DEPTH(4), .ISSUE_GAP(1)) dut_b (
    .clk(clk), .reset(reset), .bus(ib)
`ifdef FEEDER_STATS_EN
    , .issued_cnt(b_issued), .stall_cnt(b_stall)
`endif
  );
  sha_nonce_feeder #(.FIFO_DEPTH(16), .ISSUE_GAP(3)) dut_c (
    .clk(clk), .reset(reset), .bus(ic)
`ifdef FEEDER_STATS_EN
    , .issued_cnt(c_issued), .stall_cnt(c_stall)
`endif
  );

  // sha_block stand-ins: fixed-latency delay lines from en to en_next.
  logic [31:0] sr_a = '0;
  logic [31:0] sr_b = '0;
  logic [31:0] sr_c = '0;
  logic        frc_a = 1'b0;
  always @(posedge clk) begin
    sr_a <= {sr_a[30:0], ia.en === 1'b1};
    sr_b <= {sr_b[30:0], ib.en === 1'b1};
    sr_c <= {sr_c[30:0], ic.en === 1'b1};
  end
  assign ia.res_valid = sr_a[9] | frc_a;
  assign ib.res_valid = sr_b[19];
  assign ic.res_valid = sr_c[9];

  // Observation records.
  logic [31:0]  a_iss[$];
  logic [511:0] a_msg[$];
  int           a_iss_cyc[$];
  logic [31:0]  a_res[$];
  int           a_done = 0, a_done_cyc = 0, a_last_res_cyc = 0;
  logic [31:0]  b_iss[$];
  int           b_iss_cyc[$];
  logic [31:0]  b_res[$];
  int           b_done = 0;
  logic [31:0]  c_iss[$];
  int           c_iss_cyc[$];
  logic [31:0]  c_res[$];
  int           c_done = 0;

  always @(negedge clk) begin
    if (!reset) begin
      if (ia.en === 1'b1) begin
        a_iss.push_back(ia.M[415:384]); a_msg.push_back(ia.M); a_iss_cyc.push_back(cyc);
      end
      if (ia.res_nonce_valid === 1'b1) begin a_res.push_back(ia.res_nonce); a_last_res_cyc = cyc; end
      if (ia.done === 1'b1) begin a_done++; a_done_cyc = cyc; end
      if (ib.en === 1'b1) begin b_iss.push_back(ib.M[415:384]); b_iss_cyc.push_back(cyc); end
      if (ib.res_nonce_valid === 1'b1) b_res.push_back(ib.res_nonce);
      if (ib.done === 1'b1) b_done++;
      if (ic.en === 1'b1) begin c_iss.push_back(ic.M[415:384]); c_iss_cyc.push_back(cyc); end
      if (ic.res_nonce_valid === 1'b1) c_res.push_back(ic.res_nonce);
      if (ic.done === 1'b1) c_done++;
    end
  end

  // Reference model: the ordered nonce list of a run, and the padded block.
  logic [31:0] exp_q[$];
  function automatic void model_range(input logic [31:0] s, input logic [31:0] e);
    logic [31:0] n;
    n = s;
    exp_q.delete();
    for (int k = 0; k < 4096; k++) begin
      exp_q.push_back(n);
      if (n == e) break;
      n = n + 32'd1;
    end
  endfunction

  function automatic logic [511:0] model_msg(input logic [95:0] h, input logic [31:0] n);
    logic [511:0] m;
    m = '0;
    m[511:416] = h;
    m[415:384] = n;
    m[383:352] = 32'h80000000;
    m[31:0]    = 32'h00000280;
    return m;
  endfunction

  task automatic clear_a();
    a_iss.delete(); a_msg.delete(); a_iss_cyc.delete(); a_res.delete();
    a_done = 0; a_done_cyc = 0; a_last_res_cyc = 0;
  endtask

  task automatic start_a(input logic [95:0] h, input logic [31:0] s, input logic [31:0] e);
    @(negedge clk);
    ia.hdr_tail = h; ia.nonce_start = s; ia.nonce_end = e; ia.start = 1'b1;
    @(negedge clk);
    ia.start = 1'b0;
  endtask

  task automatic wait_done_a(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (a_done != 0) begin ok = 1'b1; break; end
    end
    repeat (4) @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp++; if (ia.M !== '0)  begin n_bad++; $display("FAIL reset_M: got %h want 0", ia.M); end
    n_cmp++; if (ia.en !== 1'b0)   begin n_bad++; $display("FAIL reset_en: got %b want 0", ia.en); end
    n_cmp++; if (ia.busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", ia.busy); end
    n_cmp++; if (ia.done !== 1'b0) begin n_bad++; $display("FAIL reset_done: got %b want 0", ia.done); end
    n_cmp++; if (ia.err !== 1'b0)  begin n_bad++; $display("FAIL reset_err: got %b want 0", ia.err); end
    n_cmp++; if (ib.busy !== 1'b0 || ic.en !== 1'b0)
      begin n_bad++; $display("FAIL reset_bc: got busy_b=%b en_c=%b want 0 0", ib.busy, ic.en); end
    reset = 1'b0;
    @(negedge clk);
    n_cmp++; if (ia.res_nonce_valid !== 1'b0)
      begin n_bad++; $display("FAIL reset_rnv: got %b want 0", ia.res_nonce_valid); end
  endtask

  task automatic test_basic();
    bit ok;
    logic [95:0] h;
    h = 96'h11111111_22222222_33333333;
    clear_a(); model_range(32'd5, 32'd8);
    start_a(h, 32'd5, 32'd8);
    wait_done_a(200, ok);
    n_cmp++; if (ok !== 1'b1) begin n_bad++; $display("FAIL basic_done_timeout: got %b want 1", ok); end
    n_cmp++; if (a_iss.size() != 4) begin n_bad++; $display("FAIL basic_issue_count: got %0d want 4", a_iss.size()); end
    for (int i = 0; i < a_msg.size() && i < exp_q.size(); i++) begin
      n_cmp++;
      if (a_msg[i] !== model_msg(h, exp_q[i]))
        begin n_bad++; $display("FAIL basic_msg[%0d]: got %h want %h", i, a_msg[i], model_msg(h, exp_q[i])); end
      n_cmp++;
      if (a_iss_cyc[i] != a_iss_cyc[0] + i)
        begin n_bad++; $display("FAIL basic_en_consecutive[%0d]: got cycle %0d want %0d", i, a_iss_cyc[i], a_iss_cyc[0] + i); end
    end
    n_cmp++; if (a_res.size() != 4) begin n_bad++; $display("FAIL basic_res_count: got %0d want 4", a_res.size()); end
    for (int i = 0; i < a_res.size() && i < exp_q.size(); i++) begin
      n_cmp++;
      if (a_res[i] !== exp_q[i]) begin n_bad++; $display("FAIL basic_res[%0d]: got %h want %h", i, a_res[i], exp_q[i]); end
    end
    n_cmp++; if (a_done != 1) begin n_bad++; $display("FAIL basic_done_count: got %0d want 1", a_done); end
    n_cmp++; if (!(a_done_cyc > a_last_res_cyc))
      begin n_bad++; $display("FAIL basic_done_after_res: got done %0d last res %0d", a_done_cyc, a_last_res_cyc); end
    n_cmp++; if (ia.busy !== 1'b0) begin n_bad++; $display("FAIL basic_busy_after: got %b want 0", ia.busy); end
    n_cmp++; if (ia.err !== 1'b0)  begin n_bad++; $display("FAIL basic_err: got %b want 0", ia.err); end
  endtask

  task automatic test_wrap();
    bit ok;
    clear_a(); model_range(32'hFFFFFFFE, 32'h00000001);
    start_a(96'hA5A5A5A5_5A5A5A5A_0F0F0F0F, 32'hFFFFFFFE, 32'h00000001);
    wait_done_a(200, ok);
    n_cmp++; if (ok !== 1'b1) begin n_bad++; $display("FAIL wrap_done_timeout: got %b want 1", ok); end
    n_cmp++; if (a_iss.size() != exp_q.size())
      begin n_bad++; $display("FAIL wrap_issue_count: got %0d want %0d", a_iss.size(), exp_q.size()); end
    for (int i = 0; i < a_iss.size() && i < exp_q.size(); i++) begin
      n_cmp++;
      if (a_iss[i] !== exp_q[i]) begin n_bad++; $display("FAIL wrap_iss[%0d]: got %h want %h", i, a_iss[i], exp_q[i]); end
    end
    n_cmp++; if (a_res.size() != 4) begin n_bad++; $display("FAIL wrap_res_count: got %0d want 4", a_res.size()); end
  endtask

  task automatic test_backpressure();
    bit ok;
    b_iss.delete(); b_iss_cyc.delete(); b_res.delete(); b_done = 0;
    model_range(32'd0, 32'd9);
    @(negedge clk);
    ib.hdr_tail = 96'hDEADBEEF_CAFEF00D_01234567; ib.nonce_start = 32'd0; ib.nonce_end = 32'd9; ib.start = 1'b1;
    @(negedge clk);
    ib.start = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (b_done != 0) begin ok = 1'b1; break; end
    end
    repeat (4) @(negedge clk);
    n_cmp++; if (ok !== 1'b1) begin n_bad++; $display("FAIL bp_done_timeout: got %b want 1", ok); end
    n_cmp++; if (b_iss.size() != 10) begin n_bad++; $display("FAIL bp_issue_count: got %0d want 10", b_iss.size()); end
    n_cmp++; if (b_res.size() != 10) begin n_bad++; $display("FAIL bp_res_count: got %0d want 10", b_res.size()); end
    for (int i = 0; i < b_res.size() && i < exp_q.size(); i++) begin
      n_cmp++;
      if (b_res[i] !== exp_q[i]) begin n_bad++; $display("FAIL bp_res[%0d]: got %h want %h", i, b_res[i], exp_q[i]); end
    end
    // Four back-to-back issues fill the FIFO; each later issue follows a pop
    // of the entry four places earlier (20-cycle latency + 2 cycles).
    for (int i = 4; i < b_iss_cyc.size(); i++) begin
      n_cmp++;
      if (b_iss_cyc[i] - b_iss_cyc[i-4] != 22)
        begin n_bad++; $display("FAIL bp_resume[%0d]: got spacing %0d want 22", i, b_iss_cyc[i] - b_iss_cyc[i-4]); end
    end
    n_cmp++; if (ib.err !== 1'b0) begin n_bad++; $display("FAIL bp_err: got %b want 0", ib.err); end
`ifdef FEEDER_STATS_EN
    n_cmp++; if ((b_stall != 32'd0) !== 1'b1) begin n_bad++; $display("FAIL bp_stall_cnt: got %0d want nonzero", b_stall); end
`endif
  endtask

  task automatic test_stop();
    bit ok;
    int k;
    clear_a(); k = 0;
    start_a(96'h0, 32'd0, 32'd1000);
    for (int i = 0; i < 100; i++) begin
      if (ia.en === 1'b1) k++;
      if (k == 3) break;
      @(negedge clk);
    end
    n_cmp++; if (k != 3) begin n_bad++; $display("FAIL stop_three_en: got %0d want 3", k); end
    ia.stop = 1'b1;
    @(negedge clk);
    ia.stop = 1'b0;
    n_cmp++; if (ia.en !== 1'b0) begin n_bad++; $display("FAIL stop_en_after: got %b want 0", ia.en); end
    ia.nonce_start = 32'd500; ia.nonce_end = 32'd510; ia.start = 1'b1;
    @(negedge clk);
    ia.start = 1'b0;
    wait_done_a(200, ok);
    repeat (20) @(negedge clk);
    n_cmp++; if (ok !== 1'b1) begin n_bad++; $display("FAIL stop_done_timeout: got %b want 1", ok); end
    n_cmp++; if (a_iss.size() != 3) begin n_bad++; $display("FAIL stop_issue_count: got %0d want 3", a_iss.size()); end
    n_cmp++; if (a_res.size() != 3) begin n_bad++; $display("FAIL stop_res_count: got %0d want 3", a_res.size()); end
    for (int i = 0; i < a_res.size(); i++) begin
      n_cmp++;
      if (a_res[i] !== 32'(i)) begin n_bad++; $display("FAIL stop_res[%0d]: got %h want %h", i, a_res[i], 32'(i)); end
    end
    n_cmp++; if (a_done != 1) begin n_bad++; $display("FAIL stop_done_count: got %0d want 1", a_done); end
    n_cmp++; if (ia.busy !== 1'b0) begin n_bad++; $display("FAIL stop_busy: got %b want 0", ia.busy); end
  endtask

  task automatic test_err_reset();
    bit ok;
    int k;
    repeat (15) @(negedge clk);
    frc_a = 1'b1;
    #1;
    n_cmp++; if (ia.res_nonce_valid !== 1'b0)
      begin n_bad++; $display("FAIL err_rnv_empty: got %b want 0", ia.res_nonce_valid); end
    @(negedge clk);
    frc_a = 1'b0;
    n_cmp++; if (ia.err !== 1'b1) begin n_bad++; $display("FAIL err_set: got %b want 1", ia.err); end
    clear_a();
    start_a(96'h1, 32'd7, 32'd7);
    n_cmp++; if (ia.err !== 1'b0) begin n_bad++; $display("FAIL err_cleared_by_start: got %b want 0", ia.err); end
    wait_done_a(100, ok);
    n_cmp++; if (ok !== 1'b1 || a_iss.size() != 1)
      begin n_bad++; $display("FAIL single_nonce: got done=%b issues=%0d want 1 1", ok, a_iss.size()); end
    n_cmp++; if (a_res.size() != 1 || a_res[0] !== 32'd7)
      begin n_bad++; $display("FAIL single_res: got count %0d want 1 with nonce 7", a_res.size()); end

    // reset in the middle of RUN
    clear_a(); k = 0;
    start_a(96'h2, 32'd0, 32'd1000);
    for (int i = 0; i < 100; i++) begin
      if (ia.en === 1'b1) k++;
      if (k == 5) break;
      @(negedge clk);
    end
    reset = 1'b1;
    @(negedge clk);
    n_cmp++; if (ia.en !== 1'b0)   begin n_bad++; $display("FAIL midreset_en: got %b want 0", ia.en); end
    n_cmp++; if (ia.busy !== 1'b0) begin n_bad++; $display("FAIL midreset_busy: got %b want 0", ia.busy); end
    reset = 1'b0;
    a_res.delete();
    frc_a = 1'b1;
    #1;
    n_cmp++; if (ia.res_nonce_valid !== 1'b0)
      begin n_bad++; $display("FAIL midreset_fifo_empty: got rnv %b want 0", ia.res_nonce_valid); end
    @(negedge clk);
    frc_a = 1'b0;
    repeat (15) @(negedge clk);
    n_cmp++; if (ia.err !== 1'b1) begin n_bad++; $display("FAIL midreset_late_err: got %b want 1", ia.err); end
    n_cmp++; if (a_res.size() != 0) begin n_bad++; $display("FAIL midreset_no_pairs: got %0d want 0", a_res.size()); end
  endtask

  task automatic test_gap();
    bit ok;
    c_iss.delete(); c_iss_cyc.delete(); c_res.delete(); c_done = 0;
    @(negedge clk);
    ic.hdr_tail = 96'h3; ic.nonce_start = 32'd0; ic.nonce_end = 32'd3; ic.start = 1'b1;
    @(negedge clk);
    ic.start = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (c_done != 0) begin ok = 1'b1; break; end
    end
    repeat (4) @(negedge clk);
    n_cmp++; if (ok !== 1'b1 || c_iss.size() != 4)
      begin n_bad++; $display("FAIL gap_run: got done=%b issues=%0d want 1 4", ok, c_iss.size()); end
    for (int i = 1; i < c_iss_cyc.size(); i++) begin
      n_cmp++;
      if (c_iss_cyc[i] - c_iss_cyc[i-1] != 3)
        begin n_bad++; $display("FAIL gap_spacing[%0d]: got %0d want 3", i, c_iss_cyc[i] - c_iss_cyc[i-1]); end
    end
    for (int i = 0; i < c_res.size(); i++) begin
      n_cmp++;
      if (c_res[i] !== 32'(i)) begin n_bad++; $display("FAIL gap_res[%0d]: got %h want %h", i, c_res[i], 32'(i)); end
    end
`ifdef FEEDER_STATS_EN
    n_cmp++; if (c_issued !== 32'd4) begin n_bad++; $display("FAIL gap_issued_cnt: got %0d want 4", c_issued); end
`endif
  endtask

  task automatic test_random();
    bit ok;
    logic [95:0] h;
    logic [31:0] s, e;
    for (int it = 0; it < 6; it++) begin
      h = {$urandom, $urandom, $urandom};
      s = (it % 2 == 1) ? (32'hFFFFFFFF - 32'($urandom_range(0, 5))) : $urandom;
      e = s + 32'($urandom_range(0, 11));
      clear_a(); model_range(s, e);
      start_a(h, s, e);
      wait_done_a(300, ok);
      n_cmp++; if (ok !== 1'b1) begin n_bad++; $display("FAIL rand%0d_timeout: got %b want 1", it, ok); end
      n_cmp++; if (a_iss.size() != exp_q.size() || a_res.size() != exp_q.size())
        begin n_bad++; $display("FAIL rand%0d_count: got iss %0d res %0d want %0d", it, a_iss.size(), a_res.size(), exp_q.size()); end
      for (int i = 0; i < a_msg.size() && i < exp_q.size(); i++) begin
        n_cmp++;
        if (a_msg[i] !== model_msg(h, exp_q[i]))
          begin n_bad++; $display("FAIL rand%0d_msg[%0d]: got %h want %h", it, i, a_msg[i], model_msg(h, exp_q[i])); end
      end
      for (int i = 0; i < a_res.size() && i < exp_q.size(); i++) begin
        n_cmp++;
        if (a_res[i] !== exp_q[i]) begin n_bad++; $display("FAIL rand%0d_res[%0d]: got %h want %h", it, i, a_res[i], exp_q[i]); end
      end
      n_cmp++; if (a_done != 1 || ia.err !== 1'b0)
        begin n_bad++; $display("FAIL rand%0d_status: got done %0d err %b want 1 0", it, a_done, ia.err); end
    end
  endtask

  initial begin
    ia.start = 1'b0; ia.stop = 1'b0; ia.hdr_tail = '0; ia.nonce_start = '0; ia.nonce_end = '0;
    ib.start = 1'b0; ib.stop = 1'b0; ib.hdr_tail = '0; ib.nonce_start = '0; ib.nonce_end = '0;
    ic.start = 1'b0; ic.stop = 1'b0; ic.hdr_tail = '0; ic.nonce_start = '0; ic.nonce_end = '0;
    test_reset();
    test_basic();
    test_wrap();
    test_backpressure();
    test_stop();
    test_err_reset();
    test_gap();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/sha_nonce_feeder.md
Name: sha_nonce_feeder

Overview:
- Upstream stage of sha_block in the bitcoin miner.
- Latches the 96-bit header tail and a nonce range, then builds one padded 512-bit message (`MSG_S`) per nonce and pulses en into sha_block.
- Holds every in-flight nonce in a FIFO and pops it when sha_block raises en_next, so each hash result is paired with its nonce.

Parameters:
- FIFO_DEPTH, 16: in-flight nonce capacity. Must be a power of 2 and at least the sha_block latency + 1.
- ISSUE_GAP, 1: minimum cycles between en pulses (1 = one pulse per cycle). Legal range 1..255.

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- start  input  1  one-cycle request; begin a run (accepted only in IDLE)
- stop  input  1  abort issuing; in-flight hashes still drain
- hdr_tail  input  96  {merkle_tail, time, bits}; bits [95:64] = merkle_tail
- nonce_start  input  32  first nonce
- nonce_end  input  32  last nonce, inclusive
- M  output  `MSG_S  message to sha_block
- en  output  1  one-cycle issue strobe to sha_block
- res_valid  input  1  sha_block en_next
- res_nonce  output  32  nonce for the current res_valid (FIFO head)
- res_nonce_valid  output  1  res_valid && !fifo_empty
- busy  output  1  high in RUN or DRAIN
- done  output  1  one-cycle pulse at the end of a run
- err  output  1  sticky: result arrived with the FIFO empty

Behaviour:
- Reset values: M=0, en=0, busy=0, done=0, err=0. FIFO empty, gap counter=0, state=IDLE.
- Message layout, registered and driven together with en:
  - M[511:416] = hdr_tail
  - M[415:384] = nonce
  - M[383:352] = 32'h80000000
  - M[351:32] = 0
  - M[31:0] = 32'h00000280 (640-bit length)
- States: IDLE, RUN, DRAIN, DONE.
- IDLE:
  - start=1 latches hdr_tail, sets cur_nonce=nonce_start, clears err, goes to RUN.
  - start is ignored in every other state.
- RUN, issue slot: gap counter==0 and FIFO not full.
  - On an issue slot, the next cycle shows en=1 with M built from cur_nonce, and cur_nonce is pushed into the FIFO.
  - The gap counter reloads to ISSUE_GAP-1.
  - If cur_nonce==nonce_end, go to DRAIN. Otherwise cur_nonce increments mod 2^32, so 0xFFFFFFFF wraps to 0.
  - A range with end<start therefore wraps. start==end issues exactly one nonce.
- RUN, no slot: en=0 and M holds its last value. A full FIFO stalls issue; no nonce is skipped.
- stop=1 in RUN moves to DRAIN with no issue that cycle. stop and an issue slot in the same cycle: stop wins.
- stop is ignored outside RUN.
- DRAIN: no issue. Stay until the FIFO is empty, then go to DONE.
- DONE: done=1 for one cycle, then IDLE. busy=0 in DONE.
- Result pairing, combinational from FIFO head, zero latency (aligned with the H output of sha_block):
  - res_nonce = FIFO head.
  - res_nonce_valid = res_valid && !empty.
  - That cycle pops the FIFO.
- res_valid with the FIFO empty sets err (sticky), pops nothing, and keeps res_nonce_valid=0.
- Push and pop in the same cycle leave the occupancy unchanged. Full is evaluated before the pop, so a full FIFO never pushes even when a pop occurs.
- res_valid is honoured in every state, including IDLE (for late results).
- reset mid-run returns to IDLE at once and flushes the FIFO. Any sha_block results still in flight then raise err.

Optional Feature:
- Macro: FEEDER_STATS_EN.
- Defined:
  - Adds output issued_cnt [31:0], which counts en pulses since the last accepted start (cleared on start and on reset, saturating at 0xFFFFFFFF).
  - Adds output stall_cnt [31:0], which counts RUN cycles blocked only by a full FIFO.
- Not defined: neither port exists and no counter logic is synthesised.

Test Plan:
- Basic run:
  - Stimulus: reset, then start with hdr_tail=96'h11111111_22222222_33333333, nonce_start=5, nonce_end=8; model sha_block as a fixed 10-cycle delay.
  - Response: 4 consecutive en pulses with M[415:384]=5,6,7,8, M[383:352]=32'h80000000 and M[31:0]=32'h280; res_nonce 5..8 in order; one done pulse after the 4th result; busy low after that.
- Wrap:
  - Stimulus: nonce_start=32'hFFFFFFFE, nonce_end=32'h00000001.
  - Response: issues FFFFFFFE, FFFFFFFF, 0, 1, then DRAIN.
- Backpressure:
  - Stimulus: FIFO_DEPTH=4, delay 20, range 0..9.
  - Response: en stalls after 4 issues; issuing resumes one per pop; all 10 nonces are returned in order; no err.
- Stop mid-run:
  - Stimulus: range 0..1000; assert stop after the 3rd en.
  - Response: no further en; 3 results paired 0, 1, 2; done pulses once; start while busy is ignored.
- Error and reset:
  - Stimulus: res_valid in IDLE with the FIFO empty.
  - Response: err=1 and res_nonce_valid=0; the next start clears err.
  - Stimulus: reset in the middle of RUN.
  - Response: en=0, busy=0, FIFO empty the next cycle.
- Gap:
  - Stimulus: ISSUE_GAP=3, range 0..3.
  - Response: en pulses spaced exactly 3 cycles apart.
  - With FEEDER_STATS_EN defined: issued_cnt reads 4 after the run.
